// File: rtl/skid_buffer_if.sv
// Handshake bundle for skid_buffer: upstream valid/ready/data, downstream
// valid/ready/data, the downstream load enable and the occupancy count.
// The master modport is the side that drives the stage's inputs; the slave
// modport is the stage itself.
interface skid_buffer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             load_en;
    logic [1:0]       count;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  load_en,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output load_en,
        output count
    );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline stage (main + skid register).
// Full throughput with one cycle of latency; in_ready is a flop, so there is
// no combinational path from out_ready to in_ready. load_en (out_valid &
// out_ready) is the only combinational output and feeds downstream flop
// enables.
// Optional feature macro: SKID_FLUSH_EN adds a synchronous flush input that
// empties the stage without touching the data registers.
module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
`ifdef SKID_FLUSH_EN
    input logic          flush,
`endif
    skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic             in_fire;
    logic             out_fire;
    logic             flush_req;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

`ifdef SKID_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.count     = count_q;
    assign bus.load_en   = out_valid_q & bus.out_ready;

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush empties the stage regardless of either handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (in_fire && !out_fire) begin
                    state_d = StFull;
                end else if (!in_fire && out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_fire) begin
                    state_d = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush_req) begin
            state_d = StEmpty;
        end
    end

    // Data-register enables and next values of the registered status outputs.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        unique case (state_q)
            StEmpty: main_load = in_fire;
            StBusy: begin
                main_load = in_fire & out_fire;
                skid_load = in_fire & ~out_fire;
            end
            StFull: begin
                main_load      = out_fire;
                main_from_skid = 1'b1;
            end
            default: ;
        endcase
        // A flushed word is dropped; the data registers simply hold.
        if (flush_req) begin
            main_load = 1'b0;
            skid_load = 1'b0;
        end

        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
        unique case (state_d)
            StBusy:  count_d = 2'd1;
            StFull:  count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    // Enable-flop data registers: main takes the skid word when draining FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load) begin
                main_q <= main_from_skid ? skid_q : bus.in_data;
            end
            if (skid_load) begin
                skid_q <= bus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_skid_buffer.sv
// Self-checking bench for skid_buffer. A queue of words models the stage's
// contents; every cycle the registered outputs and load_en are compared
// against what that queue implies.
module tb_skid_buffer;

    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    int n_asserts = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] last_main = '0;

    skid_buffer_if #(.WIDTH(WIDTH)) bus ();

    skid_buffer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef SKID_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check load_en against the inputs, apply the edge to the
    // model, then check the registered outputs just after the edge.
    task automatic cycle();
        bit fi;
        bit fo;
        logic [WIDTH-1:0] din;
        #1;
        fi  = bus.in_valid && (mq.size() < 2);
        fo  = bus.out_ready && (mq.size() > 0);
        din = bus.in_data;
        if (!reset) begin
            chk("load_en", {31'd0, bus.load_en}, {31'd0, fo});
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            last_main = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (fo) void'(mq.pop_front());
            if (fi) mq.push_back(din);
        end
        if (mq.size() > 0) last_main = mq[0];
        #1;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
        chk("count", {30'd0, bus.count}, mq.size());
        chk("out_data", {24'd0, bus.out_data}, {24'd0, last_main});
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
    endtask

    initial begin
        logic [WIDTH-1:0] stream [4];
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;

        // Reset held two cycles with in_valid asserted.
        drive(1'b1, 8'hEE, 1'b1);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_count", {30'd0, bus.count}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);

        // Back-to-back streaming with the downstream always ready.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, stream[i], 1'b1);
            cycle();
            chk("stream_data", {24'd0, bus.out_data}, {24'd0, stream[i]});
        end
        drive(1'b0, 8'h00, 1'b1);
        cycle();

        // Backpressure: two words fit, the third waits upstream.
        drive(1'b1, 8'hA1, 1'b0);
        cycle();
        drive(1'b1, 8'hA2, 1'b0);
        cycle();
        drive(1'b1, 8'hA3, 1'b0);
        cycle();
        cycle();
        chk("bp_count", {30'd0, bus.count}, 32'd2);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head", {24'd0, bus.out_data}, 32'hA1);
        // FULL drain with input still offered: back to BUSY with the skid word.
        drive(1'b1, 8'hA3, 1'b1);
        cycle();
        chk("drain_count", {30'd0, bus.count}, 32'd1);
        chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("drain_data", {24'd0, bus.out_data}, 32'hA2);
        cycle();
        chk("a3_data", {24'd0, bus.out_data}, 32'hA3);
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        cycle();

        // Reset while FULL drops both entries.
        drive(1'b1, 8'hB1, 1'b0);
        cycle();
        drive(1'b1, 8'hB2, 1'b0);
        cycle();
        chk("pre_rst_count", {30'd0, bus.count}, 32'd2);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        cycle();
        reset = 1'b0;
        chk("mid_rst_count", {30'd0, bus.count}, 32'd0);
        for (int i = 0; i < 3; i++) cycle();

`ifdef SKID_FLUSH_EN
        // Flush while FULL: the offered word 0x5A is dropped.
        drive(1'b1, 8'hC1, 1'b0);
        cycle();
        drive(1'b1, 8'hC2, 1'b0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 8'h5A, 1'b0);
        cycle();
        flush = 1'b0;
        chk("flush_count", {30'd0, bus.count}, 32'd0);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
`endif

        // Randomised traffic with occasional reset (and flush when present).
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 63) == 0);
`ifdef SKID_FLUSH_EN
            flush = ($urandom_range(0, 31) == 0);
`endif
            cycle();
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
